// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, overflow/underflow
// error pulses and a selectable first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_r;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance: a write into a full FIFO is allowed only when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = rd & ~empty;
        wr_acc = wr & (~full | rd_acc);
    end

    // Status flags decode straight from the count register so they move on the same edge as count.
    always_comb begin
        count        = count_r;
        full         = (count_r == FULL_C);
        empty        = (count_r == '0);
        almost_full  = (count_r >= AF_C);
        almost_empty = (count_r <= AE_C);
    end

    // Pointers, occupancy and the registered error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            overflow  <= wr & ~wr_acc;
            underflow <= rd & ~rd_acc;
        end
    end

    // Storage array; contents are not reset and are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally from the registered read pointer.
            always_comb begin
                data_out = empty ? '0 : mem[rd_ptr];
                valid    = ~empty;
            end
        end else begin : g_std
            logic [DATA_W-1:0] data_out_r;
            logic              valid_r;

            // Registered read port: one valid pulse per accepted read, data held otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_out_r <= '0;
                    valid_r    <= 1'b0;
                end else begin
                    valid_r <= rd_acc;
                    if (rd_acc) data_out_r <= mem[rd_ptr];
                end
            end

            // Drive the ports from the read-port registers.
            always_comb begin
                data_out = data_out_r;
                valid    = valid_r;
            end
        end
    endgenerate

endmodule
